hp_glitch_monitor: RTL and testbench



---
 rtl/hp_glitch_monitor_if.sv | 37 +++
 rtl/hp_glitch_monitor.sv | 164 ++++++++++++++++
 tb/tb_hp_glitch_monitor.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hp_glitch_monitor_if.sv
// Bundles the per-channel stimulus and status signals of the glitch monitor.
//   slave  : the monitor (consumes en/rx/clr, produces tx and status)
//   master : whoever drives the channels and reads back status
//   en        : per-channel enable
//   rx        : returned pattern per channel
//   clr       : per-channel alarm/counter clear pulse
//   tx        : driven test pattern per channel
//   err_cnt   : flattened error counters, channel i at [i*CNT_W +: CNT_W]
//   ch_alarm  : sticky per-channel alarm
//   alarm     : OR of ch_alarm
//   fault_id  : index of the first channel to alarm
//   fault_vld : fault_id is valid
interface hp_glitch_monitor_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int ID_W  = (NCH > 1) ? $clog2(NCH) : 1
);
   logic [NCH-1:0]       en;
   logic [NCH-1:0]       rx;
   logic [NCH-1:0]       clr;
   logic [NCH-1:0]       tx;
   logic [NCH*CNT_W-1:0] err_cnt;
   logic [NCH-1:0]       ch_alarm;
   logic                 alarm;
   logic [ID_W-1:0]      fault_id;
   logic                 fault_vld;

   modport master (
      output en, rx, clr,
      input  tx, err_cnt, ch_alarm, alarm, fault_id, fault_vld
   );

   modport slave (
      input  en, rx, clr,
      output tx, err_cnt, ch_alarm, alarm, fault_id, fault_vld
   );
endinterface

// File: rtl/hp_glitch_monitor.sv
// Multi-channel clock/supply glitch monitor.
// Each channel drives an f/4 toggle pattern on tx, compares the returned rx
// against a latency-matched copy, integrates mismatches in a leaky-bucket
// counter and raises a sticky alarm once the count reaches THRESH. The first
// channel to alarm is reported on fault_id.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   mon   : hp_glitch_monitor_if slave modport (en, rx, clr in;
//           tx, err_cnt, ch_alarm, alarm, fault_id, fault_vld out)
module hp_glitch_monitor #(
   parameter int NCH    = 4,
   parameter int LAT    = 2,
   parameter int CNT_W  = 8,
   parameter int THRESH = 1,
   parameter int DECAY  = 256,
   parameter int INVERT = 0
) (
   input  logic                clk,
   input  logic                reset,
   hp_glitch_monitor_if.slave  mon
);
   localparam int ID_W    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int ARM_MAX = LAT + 2;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);
   localparam int DEC_W   = (DECAY > 1) ? $clog2(DECAY) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
   localparam logic [ARM_W-1:0] ARM_TOP = ARM_W'(ARM_MAX);
   localparam logic             PH_TGL  = 1'(INVERT);

   logic                 ph_q;
   logic [NCH-1:0]       tx_q, tx_d;
   logic [NCH-1:0]       exp_v;
   logic [NCH-1:0]       al_q, al_d;
   logic [NCH-1:0]       armed, mis;
   logic [CNT_W-1:0]     cnt_q [NCH];
   logic [CNT_W-1:0]     cnt_d [NCH];
   logic [ARM_W-1:0]     arm_q [NCH];
   logic [ARM_W-1:0]     arm_d [NCH];
   logic                 tick;
   logic                 fv_q;
   logic [ID_W-1:0]      fid_q, first_idx;

   // Expected pattern: tx delayed by LAT registers to match the external path.
   generate
      if (LAT == 0) begin : g_nolat
         assign exp_v = tx_q;
      end else begin : g_lat
         logic [NCH-1:0] pipe [LAT];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < LAT; k++) pipe[k] <= '0;
            end else begin
               pipe[0] <= tx_q;
               for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
         end
         assign exp_v = pipe[LAT-1];
      end
   endgenerate

   // Leak tick: one cycle in every DECAY; DECAY=0 never leaks.
   generate
      if (DECAY == 0) begin : g_nodecay
         assign tick = 1'b0;
      end else begin : g_decay
         logic [DEC_W-1:0] dcnt_q;
         always_ff @(posedge clk) begin
            if (reset)
               dcnt_q <= '0;
            else if (dcnt_q == DEC_W'(DECAY - 1))
               dcnt_q <= '0;
            else
               dcnt_q <= dcnt_q + 1'b1;
         end
         assign tick = (dcnt_q == DEC_W'(DECAY - 1));
      end
   endgenerate

   always_comb begin
      tx_d  = tx_q;
      al_d  = al_q;
      armed = '0;
      mis   = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         arm_d[i] = arm_q[i];
         armed[i] = (arm_q[i] == ARM_TOP);
         // A channel only compares once the pipeline holds pattern data
         // launched while it was enabled.
         mis[i]   = mon.en[i] & armed[i] & (mon.rx[i] ^ exp_v[i]);

         if (!mon.en[i]) begin
            tx_d[i]  = 1'b0;
            arm_d[i] = '0;
         end else begin
            if (ph_q == PH_TGL) tx_d[i] = ~tx_q[i];
            if (!armed[i])      arm_d[i] = arm_q[i] + 1'b1;
         end

         // A mismatch on a leak cycle cancels the leak instead of counting.
         if (mon.clr[i])
            cnt_d[i] = '0;
         else if (mis[i] && !tick) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!mis[i] && tick && (cnt_q[i] != '0))
            cnt_d[i] = cnt_q[i] - 1'b1;

         // Threshold check uses the registered count, so set wins over clr.
         al_d[i] = (cnt_q[i] >= THR) | (al_q[i] & ~mon.clr[i]);
      end
   end

   always_comb begin
      first_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (al_d[i]) first_idx = ID_W'(i);
      end
   end

   // fault_vld tracks the alarm registers and is updated on the same edge,
   // so it rises together with the first ch_alarm and falls once all clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph_q  <= 1'b0;
         tx_q  <= '0;
         al_q  <= '0;
         fv_q  <= 1'b0;
         fid_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
            arm_q[i] <= '0;
         end
      end else begin
         ph_q <= ~ph_q;
         tx_q <= tx_d;
         al_q <= al_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
            arm_q[i] <= arm_d[i];
         end
         if (al_d == '0)
            fv_q <= 1'b0;
         else if (!fv_q) begin
            fv_q  <= 1'b1;
            fid_q <= first_idx;
         end
      end
   end

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_flat
         assign mon.err_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
      end
   endgenerate

   assign mon.tx        = tx_q;
   assign mon.ch_alarm  = al_q;
   assign mon.alarm     = |al_q;
   assign mon.fault_id  = fid_q;
   assign mon.fault_vld = fv_q;
endmodule

// File: tb/tb_hp_glitch_monitor.sv
module tb_hp_glitch_monitor;
   localparam int NCH  = 4;
   localparam int CW   = 8;
   localparam int LATN = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hp_glitch_monitor_if #(.NCH(NCH), .CNT_W(CW)) ifa ();
   hp_glitch_monitor_if #(.NCH(NCH), .CNT_W(CW)) ifb ();

   hp_glitch_monitor #(.NCH(NCH), .LAT(LATN), .CNT_W(CW), .THRESH(1), .DECAY(256), .INVERT(0))
      dut_a (.clk(clk), .reset(reset), .mon(ifa));
   hp_glitch_monitor #(.NCH(NCH), .LAT(LATN), .CNT_W(CW), .THRESH(3), .DECAY(16), .INVERT(0))
      dut_b (.clk(clk), .reset(reset), .mon(ifb));

   // stimulus per instance: 0 = A, 1 = B
   logic [3:0] en_s  [2];
   logic [3:0] clr_s [2];
   logic [3:0] gl_s  [2];
   logic [3:0] rxm_s [2];   // 1: rx taken from rxf_s instead of loopback
   logic [3:0] rxf_s [2];
   logic [3:0] lb1a, lb2a, lb1b, lb2b;

   // two-flop external loopback path
   always @(posedge clk) begin
      if (reset) begin
         lb1a <= '0; lb2a <= '0; lb1b <= '0; lb2b <= '0;
      end else begin
         lb1a <= ifa.tx; lb2a <= lb1a;
         lb1b <= ifb.tx; lb2b <= lb1b;
      end
   end

   assign ifa.en  = en_s[0];
   assign ifa.clr = clr_s[0];
   assign ifa.rx  = (rxm_s[0] & rxf_s[0]) | (~rxm_s[0] & (lb2a ^ gl_s[0]));
   assign ifb.en  = en_s[1];
   assign ifb.clr = clr_s[1];
   assign ifb.rx  = (rxm_s[1] & rxf_s[1]) | (~rxm_s[1] & (lb2b ^ gl_s[1]));

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   int th  [2];
   int dec [2];
   int m_k;                 // edges since reset release
   int m_cnt [2][4];
   bit m_al  [2][4];
   bit m_tx  [2][4];
   bit m_h1  [2][4];        // tx one edge ago
   bit m_h2  [2][4];        // tx two edges ago (= expected and loopback rx)
   int m_run [2][4];        // consecutive enabled edges
   bit m_fv  [2];
   int m_fid [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic model_edge();
      bit tk, mis, rxv, nt, any;
      bit nal [4];
      if (reset) begin
         m_k = 0;
         for (int d = 0; d < 2; d++) begin
            m_fv[d] = 0; m_fid[d] = 0;
            for (int i = 0; i < 4; i++) begin
               m_cnt[d][i] = 0; m_al[d][i] = 0; m_tx[d][i] = 0;
               m_h1[d][i] = 0; m_h2[d][i] = 0; m_run[d][i] = 0;
            end
         end
         return;
      end
      for (int d = 0; d < 2; d++) begin
         tk = (dec[d] != 0) && ((m_k % dec[d]) == dec[d] - 1);
         for (int i = 0; i < 4; i++)
            nal[i] = (m_cnt[d][i] >= th[d]) || (m_al[d][i] && !clr_s[d][i]);
         for (int i = 0; i < 4; i++) begin
            rxv = rxm_s[d][i] ? rxf_s[d][i] : (m_h2[d][i] ^ gl_s[d][i]);
            mis = en_s[d][i] && (m_run[d][i] >= LATN + 2) && (rxv != m_h2[d][i]);
            if (clr_s[d][i])             m_cnt[d][i] = 0;
            else if (mis && !tk)         m_cnt[d][i] = (m_cnt[d][i] < 255) ? m_cnt[d][i] + 1 : 255;
            else if (!mis && tk && m_cnt[d][i] > 0) m_cnt[d][i] = m_cnt[d][i] - 1;
            m_al[d][i] = nal[i];
            // pattern toggles on even cycles after reset (INVERT = 0)
            nt = en_s[d][i] ? (((m_k % 2) == 0) ? !m_tx[d][i] : m_tx[d][i]) : 1'b0;
            m_h2[d][i] = m_h1[d][i];
            m_h1[d][i] = m_tx[d][i];
            m_tx[d][i] = nt;
            m_run[d][i] = en_s[d][i] ? ((m_run[d][i] < 1000) ? m_run[d][i] + 1 : 1000) : 0;
         end
         any = nal[0] | nal[1] | nal[2] | nal[3];
         if (!any) m_fv[d] = 0;
         else if (!m_fv[d]) begin
            m_fv[d] = 1;
            for (int i = 3; i >= 0; i--) if (nal[i]) m_fid[d] = i;
         end
      end
      m_k++;
   endtask

   task automatic compare_all();
      logic [3:0]  etx, eal, atx;
      logic [31:0] ecnt, acnt;
      logic [7:0]  ef, af;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            etx[i] = m_tx[d][i];
            eal[i] = m_al[d][i];
            ecnt[i*8 +: 8] = 8'(m_cnt[d][i]);
         end
         ef = {eal, |eal, m_fv[d], 2'(m_fid[d])};
         if (d == 0) begin
            atx = ifa.tx; acnt = ifa.err_cnt;
            af = {ifa.ch_alarm, ifa.alarm, ifa.fault_vld, ifa.fault_id};
         end else begin
            atx = ifb.tx; acnt = ifb.err_cnt;
            af = {ifb.ch_alarm, ifb.alarm, ifb.fault_vld, ifb.fault_id};
         end
         check($sformatf("model_tx%0d", d), 32'(atx), 32'(etx));
         check($sformatf("model_cnt%0d", d), acnt, ecnt);
         check($sformatf("model_flags%0d", d), 32'(af), 32'(ef));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic idle_to(input int e);
      while (m_k < e) step();
   endtask

   task automatic glitch_at(input int d, input int ch, input int e);
      idle_to(e - 1);
      gl_s[d][ch] = 1'b1;
      step();
      gl_s[d][ch] = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  gl;
      logic [3:0]  clr;
      logic [31:0] cnt;
      logic [3:0]  al;
      logic        fv;
      logic [1:0]  fid;
   } vec_t;
   vec_t tbl [16];

   initial begin
      int tog;
      logic prev;
      th[0] = 1; th[1] = 3; dec[0] = 256; dec[1] = 16;
      for (int d = 0; d < 2; d++) begin
         en_s[d] = '0; clr_s[d] = '0; gl_s[d] = '0; rxm_s[d] = '0; rxf_s[d] = '0;
      end
      m_k = 0;

      // glitch ch2, clear; glitch ch1+ch3 together, clear each; glitch ch3
      tbl[0]  = '{4'b0100, 4'b0000, 32'h0001_0000, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{4'b0000, 4'b0000, 32'h0001_0000, 4'b0100, 1'b1, 2'd2};
      tbl[2]  = '{4'b0000, 4'b0000, 32'h0001_0000, 4'b0100, 1'b1, 2'd2};
      tbl[3]  = '{4'b0000, 4'b0100, 32'h0000_0000, 4'b0100, 1'b1, 2'd2};
      tbl[4]  = '{4'b0000, 4'b0100, 32'h0000_0000, 4'b0000, 1'b0, 2'd2};
      tbl[5]  = '{4'b1010, 4'b0000, 32'h0100_0100, 4'b0000, 1'b0, 2'd2};
      tbl[6]  = '{4'b0000, 4'b0000, 32'h0100_0100, 4'b1010, 1'b1, 2'd1};
      tbl[7]  = '{4'b0000, 4'b0010, 32'h0100_0000, 4'b1010, 1'b1, 2'd1};
      tbl[8]  = '{4'b0000, 4'b0010, 32'h0100_0000, 4'b1000, 1'b1, 2'd1};
      tbl[9]  = '{4'b0000, 4'b1000, 32'h0000_0000, 4'b1000, 1'b1, 2'd1};
      tbl[10] = '{4'b0000, 4'b1000, 32'h0000_0000, 4'b0000, 1'b0, 2'd1};
      tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd1};
      tbl[12] = '{4'b1000, 4'b0000, 32'h0100_0000, 4'b0000, 1'b0, 2'd1};
      tbl[13] = '{4'b0000, 4'b0000, 32'h0100_0000, 4'b1000, 1'b1, 2'd3};
      tbl[14] = '{4'b0000, 4'b1000, 32'h0000_0000, 4'b1000, 1'b1, 2'd3};
      tbl[15] = '{4'b0000, 4'b1000, 32'h0000_0000, 4'b0000, 1'b0, 2'd3};

      // clean loopback, all channels enabled
      do_reset();
      check("reset_flags_a", 32'({ifa.tx, ifa.ch_alarm, ifa.alarm, ifa.fault_vld}), 32'd0);
      check("reset_cnt_a", ifa.err_cnt, 32'd0);
      en_s[0] = 4'hF; en_s[1] = 4'hF;
      repeat (1000) step();
      check("clean_cnt_a", ifa.err_cnt, 32'd0);
      check("clean_alarm_a", 32'({ifa.alarm, ifa.fault_vld}), 32'd0);
      tog = 0;
      prev = ifa.tx[1];
      repeat (8) begin
         step();
         if (ifa.tx[1] != prev) tog++;
         prev = ifa.tx[1];
      end
      check("tx_toggles_per_8", 32'(tog), 32'd4);

      // table-driven single-cycle scenarios on instance A
      do_reset();
      repeat (10) step();
      for (int r = 0; r < 16; r++) begin
         gl_s[0] = tbl[r].gl; clr_s[0] = tbl[r].clr;
         step();
         gl_s[0] = '0; clr_s[0] = '0;
         check($sformatf("tbl%0d_cnt", r), ifa.err_cnt, tbl[r].cnt);
         check($sformatf("tbl%0d_flags", r),
               32'({ifa.ch_alarm, ifa.alarm, ifa.fault_vld, ifa.fault_id}),
               32'({tbl[r].al, |tbl[r].al, tbl[r].fv, tbl[r].fid}));
      end

      // re-enable with garbage on rx while the channel is arming
      en_s[0][2] = 1'b0;
      repeat (10) step();
      en_s[0][2] = 1'b1;
      rxm_s[0][2] = 1'b1;
      repeat (LATN + 2) begin
         rxf_s[0][2] = 1'($urandom_range(0, 1));
         step();
      end
      rxm_s[0][2] = 1'b0;
      repeat (12) step();
      check("rearm_cnt2", 32'(ifa.err_cnt[23:16]), 32'd0);
      check("rearm_alarm", 32'(ifa.alarm), 32'd0);

      // leaky bucket on instance B (THRESH=3, DECAY=16; ticks at edges 16,32,48)
      do_reset();
      glitch_at(1, 0, 6);
      glitch_at(1, 0, 10);
      check("b_two_glitch_cnt", 32'(ifb.err_cnt[7:0]), 32'd2);
      step();
      check("b_two_glitch_noalarm", 32'(ifb.ch_alarm[0]), 32'd0);
      idle_to(32);
      check("b_leaked_cnt", 32'(ifb.err_cnt[7:0]), 32'd0);
      glitch_at(1, 0, 42);
      glitch_at(1, 0, 44);
      glitch_at(1, 0, 48);
      check("b_tick_glitch_cnt", 32'(ifb.err_cnt[7:0]), 32'd2);
      glitch_at(1, 0, 49);
      check("b_reach_thresh_cnt", 32'(ifb.err_cnt[7:0]), 32'd3);
      clr_s[1][0] = 1'b1;
      step();
      clr_s[1][0] = 1'b0;
      check("b_set_wins_alarm", 32'(ifb.ch_alarm[0]), 32'd1);
      check("b_set_wins_cnt", 32'(ifb.err_cnt[7:0]), 32'd0);

      // stuck-at-0 on B ch0 saturates; stuck-at-1 on A ch3 raises an alarm
      rxm_s[1][0] = 1'b1; rxf_s[1][0] = 1'b0;
      rxm_s[0][3] = 1'b1; rxf_s[0][3] = 1'b1;
      repeat (800) step();
      check("b_saturated", 32'(ifb.err_cnt[7:0] >= 8'd250), 32'd1);
      repeat (100) step();
      check("b_no_wrap", 32'(ifb.err_cnt[7:0] >= 8'd250), 32'd1);
      check("a_stuck_alarm", 32'(ifa.ch_alarm[3]), 32'd1);

      // reset while alarms are active
      do_reset();
      check("rst_a_outputs", 32'({ifa.tx, ifa.ch_alarm, ifa.alarm, ifa.fault_vld, ifa.fault_id}), 32'd0);
      check("rst_a_cnt", ifa.err_cnt, 32'd0);
      check("rst_b_outputs", 32'({ifb.tx, ifb.ch_alarm, ifb.alarm, ifb.fault_vld, ifb.fault_id}), 32'd0);
      check("rst_b_cnt", ifb.err_cnt, 32'd0);
      rxm_s[0] = '0; rxm_s[1] = '0;

      // randomized traffic against the reference model
      repeat (2500) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
               gl_s[d][i]  = ($urandom_range(0, 24) == 0);
               clr_s[d][i] = ($urandom_range(0, 60) == 0);
               if ($urandom_range(0, 49) == 0) en_s[d][i] = ~en_s[d][i];
               rxm_s[d][i] = ($urandom_range(0, 40) == 0);
               rxf_s[d][i] = 1'($urandom_range(0, 1));
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
